// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle controller. It holds the FSM state
// codes, the opcode and funct constants, the datapath select encodings, the
// one-hot instruction class and the per-class datapath select table.
// ----------------------------------------------------------------------------
package ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned NPC_W   = 3;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned CNT_W   = 32;

  // FSM states. Codes 5-7 are unused and recover to S_FETCH.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  // Primary opcodes taken from instr[31:26].
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // R-type funct codes taken from instr[5:0].
  localparam logic [FUNCT_W-1:0] FN_JR   = 6'h08;
  localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
  localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;

  // Next-PC select.
  localparam logic [NPC_W-1:0] NPC_PC4 = 3'd0;
  localparam logic [NPC_W-1:0] NPC_BEQ = 3'd1;
  localparam logic [NPC_W-1:0] NPC_JAL = 3'd2;
  localparam logic [NPC_W-1:0] NPC_JR  = 3'd3;

  // ALU operation.
  localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'd2;
  localparam logic [ALU_W-1:0] ALU_LUI = 4'd3;

  // ALU B-operand select.
  localparam logic [SEL_W-1:0] BSEL_RT  = 2'd0;
  localparam logic [SEL_W-1:0] BSEL_IMM = 2'd1;

  // Immediate extension mode.
  localparam logic EXT_SIGN = 1'b0;
  localparam logic EXT_ZERO = 1'b1;

  // Register-file write address select.
  localparam logic [SEL_W-1:0] A3_RD = 2'd0;
  localparam logic [SEL_W-1:0] A3_RT = 2'd1;
  localparam logic [SEL_W-1:0] A3_RA = 2'd2;

  // Register-file write data select.
  localparam logic [SEL_W-1:0] REG_ALU = 2'd0;
  localparam logic [SEL_W-1:0] REG_MEM = 2'd1;
  localparam logic [SEL_W-1:0] REG_PC4 = 2'd2;

  // One-hot instruction class. Exactly one bit is set for any opcode/funct.
  typedef struct packed {
    logic illegal;
    logic jal;
    logic lui;
    logic beq;
    logic sw;
    logic lw;
    logic ori;
    logic jr;
    logic subu;
    logic addu;
  } instr_t;

  // Datapath selects that follow the decoded instruction outside FETCH.
  typedef struct packed {
    logic [ALU_W-1:0] alu_op;
    logic [SEL_W-1:0] b_op;
    logic             zero_ext;
    logic [SEL_W-1:0] a3_op;
    logic [SEL_W-1:0] reg_op;
  } dp_sel_t;

  // Per-class datapath selects. Illegal, jr and anything unlisted keep
  // the all-zero defaults.
  function automatic dp_sel_t dp_sel_of(input instr_t cls);
    dp_sel_t sel;
    sel.alu_op   = ALU_ADD;
    sel.b_op     = BSEL_RT;
    sel.zero_ext = EXT_SIGN;
    sel.a3_op    = A3_RD;
    sel.reg_op   = REG_ALU;
    if (cls.subu || cls.beq) begin
      sel.alu_op = ALU_SUB;
    end
    if (cls.ori) begin
      sel.alu_op   = ALU_OR;
      sel.b_op     = BSEL_IMM;
      sel.zero_ext = EXT_ZERO;
      sel.a3_op    = A3_RT;
    end
    if (cls.lui) begin
      sel.alu_op = ALU_LUI;
      sel.b_op   = BSEL_IMM;
      sel.a3_op  = A3_RT;
    end
    if (cls.lw) begin
      sel.b_op   = BSEL_IMM;
      sel.a3_op  = A3_RT;
      sel.reg_op = REG_MEM;
    end
    if (cls.sw) begin
      sel.b_op = BSEL_IMM;
    end
    if (cls.jal) begin
      sel.a3_op  = A3_RA;
      sel.reg_op = REG_PC4;
    end
    return sel;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// ----------------------------------------------------------------------------
// instr_decode
// This is a purely combinational decoder. It maps an opcode and funct pair to
// a one-hot instruction class. Any encoding that is not recognised sets the
// illegal bit.
// Ports:
//   opcode_i  in  6   instr[31:26]
//   funct_i   in  6   instr[5:0], used only when the opcode is R-type
//   cls_o     out     one-hot instruction class (instr_t)
// ----------------------------------------------------------------------------
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [OP_W-1:0]    opcode_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output instr_t             cls_o
);

  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU: cls_o.addu    = 1'b1;
          FN_SUBU: cls_o.subu    = 1'b1;
          FN_JR:   cls_o.jr      = 1'b1;
          default: cls_o.illegal = 1'b1;
        endcase
      end
      OP_ORI:  cls_o.ori     = 1'b1;
      OP_LW:   cls_o.lw      = 1'b1;
      OP_SW:   cls_o.sw      = 1'b1;
      OP_BEQ:  cls_o.beq     = 1'b1;
      OP_LUI:  cls_o.lui     = 1'b1;
      OP_JAL:  cls_o.jal     = 1'b1;
      default: cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
// This is the control FSM for a multicycle MIPS-subset datapath. The states are
// FETCH, DECODE, EXE, MEM and WB. The controller drives the write enables and
// the datapath selects as functions of the current state and of the decoded IR.
// It also counts retired instructions.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   opcode, funct   IR fields from the datapath
//   PCWrite/IRWrite/RegWrite/MemWrite   write enables
//   NPCOp           next-PC select
//   ZeroEXT, A1op, A2op, A3op, REGop, REGorMEM, ALU_Aop, ALU_Bop, ALUOp
//                   datapath selects
//   state           current FSM state
//   instr_done      retire pulse, identical to PCWrite
//   retired         retired-instruction counter, wraps at 2^32
// ----------------------------------------------------------------------------
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic [NPC_W-1:0]   NPCOp,
  output logic               ZeroEXT,
  output logic [SEL_W-1:0]   A1op,
  output logic               A2op,
  output logic [SEL_W-1:0]   A3op,
  output logic [SEL_W-1:0]   REGop,
  output logic               REGorMEM,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               ALU_Aop,
  output logic [SEL_W-1:0]   ALU_Bop,
  output logic [ALU_W-1:0]   ALUOp,
  output logic [STATE_W-1:0] state,
  output logic               instr_done,
  output logic [CNT_W-1:0]   retired
);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] retired_q;
  instr_t           cls;
  dp_sel_t          sel;

  instr_decode u_instr_decode (
    .opcode_i (opcode),
    .funct_i  (funct),
    .cls_o    (cls)
  );

  assign sel = dp_sel_of(cls);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Unused codes fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = cls.illegal ? S_FETCH : S_EXE;
      S_EXE: begin
        if (cls.lw || cls.sw) begin
          state_d = S_MEM;
        end else if (cls.addu || cls.subu || cls.ori || cls.lui || cls.jal) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM:    state_d = cls.lw ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output logic. The datapath selects follow the decoded instruction in
  // every state except FETCH. The write enables depend on the state.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    NPCOp    = NPC_PC4;
    ALUOp    = ALU_ADD;
    ALU_Bop  = BSEL_RT;
    ZeroEXT  = EXT_SIGN;
    A3op     = A3_RD;
    REGop    = REG_ALU;

    if (state_q inside {S_DECODE, S_EXE, S_MEM, S_WB}) begin
      ALUOp   = sel.alu_op;
      ALU_Bop = sel.b_op;
      ZeroEXT = sel.zero_ext;
      A3op    = sel.a3_op;
      REGop   = sel.reg_op;
    end

    case (state_q)
      S_FETCH: IRWrite = 1'b1;
      S_DECODE: begin
        // An illegal instruction retires as a nop by stepping the PC.
        if (cls.illegal) begin
          PCWrite = 1'b1;
          NPCOp   = NPC_PC4;
        end
      end
      S_EXE: begin
        if (cls.beq) begin
          PCWrite = 1'b1;
          NPCOp   = NPC_BEQ;
          ALUOp   = ALU_SUB;
        end else if (cls.jr) begin
          PCWrite = 1'b1;
          NPCOp   = NPC_JR;
        end
      end
      S_MEM: begin
        if (cls.sw) begin
          MemWrite = 1'b1;
          PCWrite  = 1'b1;
          NPCOp    = NPC_PC4;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        NPCOp    = cls.jal ? NPC_JAL : NPC_PC4;
      end
      default: ;
    endcase
  end

  // Count retired instructions. An instruction retires on the edge that ends
  // its PCWrite cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (PCWrite) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign A1op       = 2'd0;
  assign A2op       = 1'b0;
  assign ALU_Aop    = 1'b0;
  assign REGorMEM   = (REGop == REG_MEM);
  assign instr_done = PCWrite;
  assign state      = state_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl
// This is a self-checking bench for multicycle_ctrl. A table-driven reference
// model gives the expected outputs for each cycle of each instruction class.
// The model covers latency, the state path, the retire cycle and the selects.
// The bench compares the model against the DUT on every cycle.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        PCWrite, IRWrite, ZeroEXT, A2op, REGorMEM, RegWrite, MemWrite;
  logic        ALU_Aop, instr_done;
  logic [2:0]  NPCOp, state;
  logic [1:0]  A1op, A3op, REGop, ALU_Bop;
  logic [3:0]  ALUOp;
  logic [31:0] retired;
  logic [26:0] obs;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .NPCOp      (NPCOp),
    .ZeroEXT    (ZeroEXT),
    .A1op       (A1op),
    .A2op       (A2op),
    .A3op       (A3op),
    .REGop      (REGop),
    .REGorMEM   (REGorMEM),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .ALU_Aop    (ALU_Aop),
    .ALU_Bop    (ALU_Bop),
    .ALUOp      (ALUOp),
    .state      (state),
    .instr_done (instr_done),
    .retired    (retired)
  );

  assign obs = {state, PCWrite, IRWrite, NPCOp, ZeroEXT, A1op, A2op, A3op,
                REGop, REGorMEM, RegWrite, MemWrite, ALU_Aop, ALU_Bop, ALUOp,
                instr_done};

  // Instruction classes and their properties.
  localparam int C_ADDU = 0, C_SUBU = 1, C_JR = 2, C_ORI = 3, C_LW = 4;
  localparam int C_SW = 5, C_BEQ = 6, C_LUI = 7, C_JAL = 8, C_ILL = 9;
  //                              addu subu jr ori lw sw beq lui jal ill
  localparam int LEN_T  [10] = '{ 4,   4,   3, 4,  5, 4, 3,  4,  4,  2 };
  localparam int NPC_T  [10] = '{ 0,   0,   3, 0,  0, 0, 1,  0,  2,  0 };
  localparam int ALU_T  [10] = '{ 0,   1,   0, 2,  0, 0, 1,  3,  0,  0 };
  localparam int B_T    [10] = '{ 0,   0,   0, 1,  1, 1, 0,  1,  0,  0 };
  localparam int Z_T    [10] = '{ 0,   0,   0, 1,  0, 0, 0,  0,  0,  0 };
  localparam int A3_T   [10] = '{ 0,   0,   0, 1,  1, 0, 0,  1,  2,  0 };
  localparam int REG_T  [10] = '{ 0,   0,   0, 0,  1, 0, 0,  0,  2,  0 };
  localparam int WR_T   [10] = '{ 1,   1,   0, 1,  1, 0, 0,  1,  1,  0 };

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_retired;

  function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        case (fn)
          6'h21:   return C_ADDU;
          6'h23:   return C_SUBU;
          6'h08:   return C_JR;
          default: return C_ILL;
        endcase
      end
      6'h0D:   return C_ORI;
      6'h23:   return C_LW;
      6'h2B:   return C_SW;
      6'h04:   return C_BEQ;
      6'h0F:   return C_LUI;
      6'h03:   return C_JAL;
      default: return C_ILL;
    endcase
  endfunction

  // Gives the expected packed outputs for cycle k of an instruction of class c.
  // Cycle 0 is FETCH. The last cycle is the retire cycle.
  function automatic logic [26:0] expect_out(input int c, input int k);
    bit         last;
    logic [2:0] st, npc;
    logic [1:0] a3, rg, bop;
    logic [3:0] alu;
    logic       z, regw, memw;
    last = (k == LEN_T[c] - 1);
    if (k < 3)                                  st = 3'(k);
    else if (k == 3 && (c == C_LW || c == C_SW)) st = 3'd3;
    else                                         st = 3'd4;
    npc  = last ? 3'(NPC_T[c]) : 3'd0;
    regw = last && (WR_T[c] == 1);
    memw = last && (c == C_SW);
    if (k == 0) begin
      a3 = 2'd0; rg = 2'd0; bop = 2'd0; alu = 4'd0; z = 1'b0;
    end else begin
      a3 = 2'(A3_T[c]); rg = 2'(REG_T[c]); bop = 2'(B_T[c]);
      alu = 4'(ALU_T[c]); z = Z_T[c][0];
    end
    return {st, last, (k == 0), npc, z, 2'd0, 1'b0, a3, rg, (rg == 2'd1),
            regw, memw, 1'b0, bop, alu, last};
  endfunction

  // Issues one instruction at a negedge while the DUT is in FETCH. The task
  // checks every cycle of the instruction and then the FETCH that follows.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn);
    int          c;
    logic [26:0] e;
    c = cls_of(op, fn);
    opcode = op;
    funct  = fn;
    #1;
    for (int k = 0; k < LEN_T[c]; k++) begin
      e = expect_out(c, k);
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s cyc%0d outputs: got %h want %h", name, k, obs, e);
      end
      n_tests++;
      if (retired !== exp_retired) begin
        n_fail++;
        $display("FAIL %s cyc%0d retired: got %h want %h", name, k, retired, exp_retired);
      end
      @(negedge clk);
    end
    exp_retired = exp_retired + 32'd1;
    n_tests++;
    if (state !== 3'd0 || retired !== exp_retired) begin
      n_fail++;
      $display("FAIL %s after-retire: state %0d retired %h want state 0 retired %h",
               name, state, retired, exp_retired);
    end
  endtask

  task automatic test_reset();
    logic [26:0] e;
    reset  = 1'b1;
    opcode = 6'h23;
    funct  = 6'h00;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      e = expect_out(C_LW, 0);
      n_tests++;
      if (obs !== e || retired !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_hold%0d: got %h/%h want %h/0", i, obs, retired, e);
      end
    end
    reset       = 1'b0;
    exp_retired = 32'd0;
  endtask

  task automatic test_alu();
    run_instr("addu", 6'h00, 6'h21);
    n_tests++;
    if (retired !== 32'd1) begin
      n_fail++;
      $display("FAIL addu_retired: got %0d want 1", retired);
    end
    run_instr("subu", 6'h00, 6'h23);
    run_instr("ori",  6'h0D, 6'h15);
    run_instr("lui",  6'h0F, 6'h2A);
  endtask

  task automatic test_mem();
    run_instr("lw", 6'h23, 6'h07);
    run_instr("sw", 6'h2B, 6'h3C);
  endtask

  task automatic test_ctrl_flow();
    run_instr("jal",     6'h03, 6'h00);
    run_instr("illegal", 6'h3F, 6'h00);
    run_instr("rt_ill",  6'h00, 6'h22);
    run_instr("beq",     6'h04, 6'h11);
    run_instr("jr",      6'h00, 6'h08);
  endtask

  task automatic test_back_to_back();
    logic [5:0] op, fn;
    for (int i = 0; i < 60; i++) begin
      fn = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 9))
        0: begin op = 6'h00; fn = 6'h21; end
        1: begin op = 6'h00; fn = 6'h23; end
        2: begin op = 6'h00; fn = 6'h08; end
        3: op = 6'h0D;
        4: op = 6'h23;
        5: op = 6'h2B;
        6: op = 6'h04;
        7: op = 6'h0F;
        8: op = 6'h03;
        default: begin
          op = 6'($urandom_range(0, 63));
          if (cls_of(op, fn) != C_ILL) op = 6'h3E;
        end
      endcase
      run_instr("random", op, fn);
    end
  endtask

  // Asserts reset in the MEM cycle of a sw. The in-flight store must not
  // retire, and the count must clear.
  task automatic test_reset_mid_sw();
    logic [26:0] e;
    opcode = 6'h2B;
    funct  = 6'($urandom_range(0, 63));
    repeat (3) @(negedge clk);
    n_tests++;
    if (state !== 3'd3 || MemWrite !== 1'b1 || retired !== exp_retired) begin
      n_fail++;
      $display("FAIL sw_mem_pre: state %0d memw %b retired %h want 3 1 %h",
               state, MemWrite, retired, exp_retired);
    end
    reset = 1'b1;
    @(negedge clk);
    e = expect_out(C_SW, 0);
    n_tests++;
    if (obs !== e || retired !== 32'd0) begin
      n_fail++;
      $display("FAIL sw_mid_reset: got %h/%h want %h/0", obs, retired, e);
    end
    reset       = 1'b0;
    exp_retired = 32'd0;
    run_instr("post_reset_addu", 6'h00, 6'h21);
  endtask

  task automatic test_wrap();
    dut.retired_q = 32'hFFFF_FFFF;
    exp_retired   = 32'hFFFF_FFFF;
    run_instr("beq_wrap", 6'h04, 6'h00);
    n_tests++;
    if (retired !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap: got %h want 0", retired);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_ctrl_flow();
    test_back_to_back();
    test_reset_mid_sw();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
